// File: rtl/foc_pkg.sv
// Shared constants and helpers for the FOC datapath blocks.
package foc_pkg;

  localparam int unsigned C2P_XY_W    = 16;
  localparam int unsigned C2P_RHO_W   = 12;
  localparam int unsigned C2P_THETA_W = 12;
  localparam int unsigned NREQ_MAX    = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  localparam int unsigned REQ_ID_W = clog2(NREQ_MAX);

  typedef logic [REQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/tag_fifo.sv
// Synchronous FIFO holding the requester ID of each in-flight c2p sample.
module tag_fifo
  import foc_pkg::*;
#(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head_c,
  output logic         empty_c
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign head_c  = mem_q[rd_ptr_q];
  assign empty_c = (count_q == '0);

endmodule

// File: rtl/c2p_arbiter.sv
// Round-robin arbiter sharing one cartesian2polar pipeline among NREQ
// requesters; results return tagged with the owning requester ID.
module c2p_arbiter
  import foc_pkg::*;
#(
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned ID_W  = clog2(NREQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*C2P_XY_W-1:0]      req_x,
  input  logic [NREQ*C2P_XY_W-1:0]      req_y,
  output logic [NREQ-1:0]               req_ready,
  output logic                          c2p_en,
  output logic signed [C2P_XY_W-1:0]    c2p_x,
  output logic signed [C2P_XY_W-1:0]    c2p_y,
  input  logic                          c2p_oen,
  input  logic [C2P_RHO_W-1:0]          c2p_rho,
  input  logic [C2P_THETA_W-1:0]        c2p_theta,
  output logic                          res_en,
  output logic [ID_W-1:0]               res_id,
  output logic [C2P_RHO_W-1:0]          res_rho,
  output logic [C2P_THETA_W-1:0]        res_theta,
  output logic                          err_orphan
);

  localparam int unsigned CNT_W = clog2(DEPTH) + 1;

  logic [ID_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]             inflight_q, inflight_d;
  logic                         c2p_en_q, c2p_en_d;
  logic [C2P_XY_W-1:0]          c2p_x_q, c2p_x_d;
  logic [C2P_XY_W-1:0]          c2p_y_q, c2p_y_d;
  logic [ID_W-1:0]              push_id_q, push_id_d;
  logic                         res_en_q, res_en_d;
  logic [ID_W-1:0]              res_id_q, res_id_d;
  logic [C2P_RHO_W-1:0]         res_rho_q, res_rho_d;
  logic [C2P_THETA_W-1:0]       res_theta_q, res_theta_d;
  logic                         err_orphan_q, err_orphan_d;

  logic [NREQ-1:0]              grant;
  logic [ID_W-1:0]              win_id;
  logic [ID_W-1:0]              idx;
  logic [C2P_XY_W-1:0]          win_x, win_y;
  logic                         can_grant, found, fire, pop;
  logic [ID_W-1:0]              fifo_head;
  logic                         fifo_empty;

  // Round-robin search from rr_ptr upward with wrap, gated by the credit.
  always_comb begin
    grant     = '0;
    win_id    = '0;
    idx       = '0;
    found     = 1'b0;
    win_x     = '0;
    win_y     = '0;
    can_grant = !rst && (inflight_q < CNT_W'(DEPTH));
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = ID_W'((32'(rr_ptr_q) + k) % NREQ);
      if (can_grant && !found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        win_id      = idx;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_x = req_x[i*C2P_XY_W +: C2P_XY_W];
        win_y = req_y[i*C2P_XY_W +: C2P_XY_W];
      end
    end
  end

  assign req_ready = grant;
  assign fire      = |(req_valid & grant);
  assign pop       = c2p_oen && !fifo_empty;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    c2p_en_d     = fire;
    c2p_x_d      = c2p_x_q;
    c2p_y_d      = c2p_y_q;
    push_id_d    = push_id_q;
    res_en_d     = pop;
    res_id_d     = res_id_q;
    res_rho_d    = res_rho_q;
    res_theta_d  = res_theta_q;
    err_orphan_d = err_orphan_q | (c2p_oen && fifo_empty);
    inflight_d   = inflight_q + CNT_W'(fire) - CNT_W'(pop);
    if (fire) begin
      rr_ptr_d  = (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + 1'b1;
      c2p_x_d   = win_x;
      c2p_y_d   = win_y;
      push_id_d = win_id;
    end
    if (pop) begin
      res_id_d    = fifo_head;
      res_rho_d   = c2p_rho;
      res_theta_d = c2p_theta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      inflight_q   <= '0;
      c2p_en_q     <= 1'b0;
      c2p_x_q      <= '0;
      c2p_y_q      <= '0;
      push_id_q    <= '0;
      res_en_q     <= 1'b0;
      res_id_q     <= '0;
      res_rho_q    <= '0;
      res_theta_q  <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      inflight_q   <= inflight_d;
      c2p_en_q     <= c2p_en_d;
      c2p_x_q      <= c2p_x_d;
      c2p_y_q      <= c2p_y_d;
      push_id_q    <= push_id_d;
      res_en_q     <= res_en_d;
      res_id_q     <= res_id_d;
      res_rho_q    <= res_rho_d;
      res_theta_q  <= res_theta_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Tag is pushed alongside the issue strobe, one cycle after the fire.
  tag_fifo #(
    .W     (ID_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (c2p_en_q),
    .din     (push_id_q),
    .pop     (pop),
    .head_c  (fifo_head),
    .empty_c (fifo_empty)
  );

  assign c2p_en     = c2p_en_q;
  assign c2p_x      = c2p_x_q;
  assign c2p_y      = c2p_y_q;
  assign res_en     = res_en_q;
  assign res_id     = res_id_q;
  assign res_rho    = res_rho_q;
  assign res_theta  = res_theta_q;
  assign err_orphan = err_orphan_q;

endmodule

// File: doc/c2p_arbiter.md
# c2p_arbiter

Round-robin arbiter that shares one `cartesian2polar` pipeline among `NREQ` requesters, for example the current-loop voltage vector, the open-loop test generator and the angle-observer paths. It accepts (x, y) requests with a valid/ready handshake and issues at most one per cycle into `cartesian2polar`. A tag FIFO records which requester each in-flight sample belongs to, so each (ρ, φ) result returns tagged with its requester ID. Results feed `svpwm` or other consumers through a shared result bus.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `DEPTH`, default 32: tag FIFO depth; the maximum number of samples in flight inside `cartesian2polar`. Power of 2.
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in NREQ: per-requester valid.
- `req_x` in NREQ×16: signed x per requester, packed, requester i at [16i+15:16i].
- `req_y` in NREQ×16: signed y per requester, packed the same way.
- `req_ready` out NREQ: grant. Combinational, one-hot or zero.
- `c2p_en` out 1: drives `cartesian2polar.i_en`.
- `c2p_x`, `c2p_y` out 16: signed, drive `i_x` / `i_y`.
- `c2p_oen` in 1: from `cartesian2polar.o_en`.
- `c2p_rho`, `c2p_theta` in 12: from `o_rho` / `o_theta`.
- `res_en` out 1: result strobe, one cycle.
- `res_id` out clog2(NREQ): requester that owns the result.
- `res_rho`, `res_theta` out 12: result magnitude and angle.
- `err_orphan` out 1: sticky. Set when a result arrives with the tag FIFO empty.

## Operation
- **Fire rule.** Requester i fires when `req_valid[i] & req_ready[i]`. A requester holds `req_x`/`req_y` stable while valid and not ready. Dropping valid without a fire is legal.
- **Grant.** A grant is possible only when `inflight < DEPTH`.
  - Search starts at `rr_ptr` and proceeds upward with wrap. The first valid requester is granted.
  - After a grant to i, `rr_ptr` becomes (i+1) mod NREQ. With no grant, `rr_ptr` is unchanged.
- **Issue.** On fire, `c2p_x`/`c2p_y` are registered from the winner's data and `c2p_en`=1 on the next cycle. The ID is pushed into the tag FIFO on that same next cycle. With no fire, `c2p_en`=0 and `c2p_x`/`c2p_y` hold their last value.
- **Return.** On `c2p_oen`=1, the arbiter pops the FIFO head and registers `res_id`=head, `res_rho`=`c2p_rho`, `res_theta`=`c2p_theta`, `res_en`=1. Results return in issue order; `cartesian2polar` is in-order and fixed-latency.
- **Orphan.** `c2p_oen`=1 with the FIFO empty drops the result, sets `err_orphan`, and leaves `res_en`=0. `err_orphan` clears only on `rst`.
- **Occupancy.** `inflight` counts 0..DEPTH. It is +1 on fire and −1 on a non-orphan return. A fire and a return in the same cycle leave it unchanged.
  - `inflight` counts from fire, not from push. This makes the FIFO and the credit consistent even though the push lags by one cycle.
  - The FIFO can never overflow.
- **Widths.** No arithmetic on the data; values pass through bit-exact. `c2p_x`/`c2p_y` are signed 16-bit, matching the `cartesian2polar` inputs.

## Timing
- Reset values: `c2p_en`=0, `c2p_x`=`c2p_y`=0, `res_en`=0, `res_id`=0, `res_rho`=`res_theta`=0, `err_orphan`=0. Also `rr_ptr`=0, `inflight`=0, FIFO empty.
- `req_ready` is 0 while `rst`=1.
- Latency from fire in cycle t:
  - `c2p_en` at t+1.
  - `c2p_oen` at t+1+L_c2p.
  - `res_en` at t+2+L_c2p.
- Throughput is one issue per cycle with any number of requesters valid. A single continuously valid requester fires every cycle.
- **Backpressure.** When `inflight`=DEPTH, all `req_ready`=0. If a return arrives in cycle t, the count drops and a fire is possible at t+1; `req_ready` is not forwarded combinationally from `c2p_oen`.
- **Reset mid-operation.** The FIFO and counters clear immediately.
  - `cartesian2polar` must be reset in the same cycles (`rstn` = ~`rst` at top level).
  - Any stale `c2p_oen` after reset is handled by the orphan rule.

## Structure
- Shared package `foc_pkg`:
  - `C2P_XY_W`=16, `C2P_RHO_W`=12, `C2P_THETA_W`=12.
  - Function `clog2`.
  - Typedef for the requester ID width.
- One sub-module, `tag_fifo`: synchronous FIFO, width clog2(NREQ), depth DEPTH, push/pop, empty flag.
- The round-robin search, `inflight` counter and output registers stay in `c2p_arbiter`.

## Test plan
- **Single requester.** NREQ=4; requester 2 valid with x=3277, y=0. Expect:
  - `req_ready[2]` in the same cycle, then `c2p_en`=1 with `c2p_x`=3277 one cycle later.
  - `res_en` with `res_id`=2 and `res_rho`≈3277, `res_theta`≈0 one cycle after `c2p_oen`.
- **Round-robin fairness.** All 4 valid for 16 cycles. Grants run 0,1,2,3,0,… (4 each), and `res_id` follows the same order.
- **Backpressure.** DEPTH=4 with a stub `cartesian2polar` of latency 10. Expect:
  - Exactly 4 fires, then `req_ready`=0 until the first return.
  - One new fire per cycle after each return; `inflight` never exceeds 4.
- **Simultaneous fire and return.** Steady stream with `inflight`=3. `inflight` stays at 3 across cycles with both a fire and a return.
- **Orphan.** Pulse `c2p_oen` with the FIFO empty. Expect `err_orphan`=1, no `res_en`, and `err_orphan` staying 1 until `rst`.
- **Mid-stream reset.** Assert `rst` for 1 cycle with 5 samples in flight. Expect:
  - All outputs at reset values and `rr_ptr`=0.
  - The next request gets `res_id` correct, and no stale result appears.
